// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array serial loader: mode encodings,
// loader FSM states and the byte-width helper.
package sa_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic MODE_STREAM  = 1'b0;
  localparam logic MODE_PRELOAD = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StDrain,
    StDone
  } sa_state_e;

endpackage

// File: rtl/sa_lane_shifter.sv
// One serial lane: a BPL-bit MSB-first shift register. After BPL shifts the
// oldest bit sits at the top, so the register contents are already the lane's
// words in ascending index order (word 0 in the low byte).
module sa_lane_shifter
  import sa_pkg::*;
#(
  parameter int unsigned WPL = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          shift_en_i,
  input  logic                          bit_i,
  output logic [WPL-1:0][BYTE_W-1:0]    words_o
);

  localparam int unsigned BPL = BYTE_W * WPL;

  logic [BPL-1:0] sreg_q;

  // Shift one bit in per accepted beat.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sreg_q <= '0;
    end else if (shift_en_i) begin
      sreg_q <= {sreg_q[BPL-2:0], bit_i};
    end
  end

  assign words_o = sreg_q;

endmodule

// File: rtl/sa_serial_loader.sv
// Bit-serial row loader for the systolic array. IN_LANES serial lanes are
// assembled into SIZE-byte rows and presented over a valid/ready interface,
// either as a counted weight preload (SIZE rows, then preload_done) or as an
// activation stream that runs until stop.
// Optional build macro: SA_LOADER_PARITY_EN adds parity_in / parity_err.
module sa_serial_loader
  import sa_pkg::*;
#(
  parameter int unsigned SIZE     = 16,
  parameter int unsigned IN_LANES = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       mode,
  input  logic                       stop,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IN_LANES-1:0]        data_in,
  output logic                       row_valid,
  input  logic                       row_ready,
  output logic [BYTE_W*SIZE-1:0]     row_data,
  output logic [$clog2(SIZE)-1:0]    row_idx,
  output logic                       row_is_weight,
  output logic                       preload_done,
  output logic                       busy
`ifdef SA_LOADER_PARITY_EN
  ,
  input  logic                       parity_in,
  output logic                       parity_err
`endif
);

  localparam int unsigned WPL   = SIZE / IN_LANES;
  localparam int unsigned BPL   = BYTE_W * WPL;
  localparam int unsigned CNT_W = $clog2(BPL + 1);
  localparam int unsigned IDX_W = $clog2(SIZE);

  sa_state_e                              state_q;
  logic [CNT_W-1:0]                       bit_cnt_q;
  logic [IDX_W-1:0]                       row_cnt_q, row_cnt_nxt, pend_idx_q;
  logic                                   pend_q;   // shift registers hold a complete row
  logic                                   stop_q;
  logic                                   weight_q;
  logic                                   done_q;
  logic                                   hold_valid_q;
  logic [BYTE_W*SIZE-1:0]                 hold_data_q;
  logic [IDX_W-1:0]                       hold_idx_q;
  logic [IN_LANES-1:0][WPL-1:0][BYTE_W-1:0] lane_words;
  logic [BYTE_W*SIZE-1:0]                 assembled;
  logic                                   beat, last_bit, move, stop_hold;

  for (genvar j = 0; j < IN_LANES; j++) begin : g_lane
    sa_lane_shifter #(
      .WPL (WPL)
    ) u_shifter (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .shift_en_i (beat),
      .bit_i      (data_in[j]),
      .words_o    (lane_words[j])
    );
  end

  // Lane j carries bytes j*WPL.., so the packed lane array is the row itself.
  assign assembled   = lane_words;
  assign beat        = in_valid && in_ready;
  assign last_bit    = beat && (bit_cnt_q == CNT_W'(BPL - 1));
  assign move        = pend_q && (!hold_valid_q || row_ready);
  assign row_cnt_nxt = (row_cnt_q == IDX_W'(SIZE - 1)) ? '0 : row_cnt_q + IDX_W'(1);
  // A latched stop takes effect only on a row boundary; hold off new beats then.
  assign stop_hold   = (state_q == StLoad) && (weight_q == MODE_STREAM) && stop_q &&
                       (bit_cnt_q == '0);
  assign in_ready    = (state_q == StLoad) && !(pend_q && !move) && !stop_hold;

  // Loader FSM with bit/row counters and the complete-row flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      row_cnt_q  <= '0;
      pend_idx_q <= '0;
      pend_q     <= 1'b0;
      stop_q     <= 1'b0;
      weight_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (move) begin
        pend_q <= 1'b0;
      end
      if (beat) begin
        if (last_bit) begin
          bit_cnt_q  <= '0;
          pend_q     <= 1'b1;
          pend_idx_q <= row_cnt_q;
          row_cnt_q  <= row_cnt_nxt;
        end else begin
          bit_cnt_q <= bit_cnt_q + CNT_W'(1);
        end
      end
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q   <= StLoad;
            bit_cnt_q <= '0;
            row_cnt_q <= '0;
            stop_q    <= 1'b0;
            weight_q  <= mode;
          end
        end
        StLoad: begin
          if (weight_q == MODE_PRELOAD) begin
            if (last_bit && (row_cnt_q == IDX_W'(SIZE - 1))) begin
              state_q <= StDrain;
            end
          end else begin
            if (stop) begin
              stop_q <= 1'b1;
            end
            if (stop_hold) begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          if (!pend_q && !hold_valid_q) begin
            if (weight_q == MODE_PRELOAD) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Holding register: refilled from the shifters, emptied by the row handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      hold_idx_q   <= '0;
    end else if (move) begin
      hold_valid_q <= 1'b1;
      hold_data_q  <= assembled;
      hold_idx_q   <= pend_idx_q;
    end else if (row_ready) begin
      hold_valid_q <= 1'b0;
    end
  end

  assign row_valid     = hold_valid_q;
  assign row_data      = hold_data_q;
  assign row_idx       = hold_idx_q;
  assign row_is_weight = weight_q;
  assign preload_done  = done_q;
  assign busy          = (state_q != StIdle);

`ifdef SA_LOADER_PARITY_EN
  logic parity_err_q;

  // Sticky even-parity error over accepted beats; cleared by a new load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err_q <= 1'b0;
    end else if ((state_q == StIdle) && start) begin
      parity_err_q <= 1'b0;
    end else if (beat && (parity_in != (^data_in))) begin
      parity_err_q <= 1'b1;
    end
  end

  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_sa_serial_loader.sv
// Bench for sa_serial_loader: a 16x8 instance for preload, back-pressure and
// reset scenarios and a 4x2 instance for stream mode. A queue of expected rows
// built from the lane-mapping rule is checked on every row handshake.
module tb_sa_serial_loader;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       sel       = 1'b0;  // 0: 16x8 instance, 1: 4x2 instance
  logic       start     = 1'b0;
  logic       mode      = 1'b0;
  logic       stop      = 1'b0;
  logic       in_valid  = 1'b0;
  logic       row_ready = 1'b1;
  logic [7:0] data_in   = '0;
  int         cur_size  = 16;
  int         cur_lanes = 8;
  int         checks    = 0;
  int         failures  = 0;
  int         done_cnt  = 0;

  logic         b_in_ready, b_row_valid, b_row_is_weight, b_preload_done, b_busy;
  logic [127:0] b_row_data;
  logic [3:0]   b_row_idx;
  logic         s_in_ready, s_row_valid, s_row_is_weight, s_preload_done, s_busy;
  logic [31:0]  s_row_data;
  logic [1:0]   s_row_idx;
`ifdef SA_LOADER_PARITY_EN
  logic parity_in = 1'b0;
  logic b_parity_err, s_parity_err;
  int   flip_beat = -1;
`endif

  sa_serial_loader #(.SIZE(16), .IN_LANES(8)) u_dut_big (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start & ~sel),
    .mode          (mode),
    .stop          (stop & ~sel),
    .in_valid      (in_valid & ~sel),
    .in_ready      (b_in_ready),
    .data_in       (data_in),
    .row_valid     (b_row_valid),
    .row_ready     (row_ready),
    .row_data      (b_row_data),
    .row_idx       (b_row_idx),
    .row_is_weight (b_row_is_weight),
    .preload_done  (b_preload_done),
    .busy          (b_busy)
`ifdef SA_LOADER_PARITY_EN
    ,
    .parity_in     (parity_in),
    .parity_err    (b_parity_err)
`endif
  );

  sa_serial_loader #(.SIZE(4), .IN_LANES(2)) u_dut_small (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start & sel),
    .mode          (mode),
    .stop          (stop & sel),
    .in_valid      (in_valid & sel),
    .in_ready      (s_in_ready),
    .data_in       (data_in[1:0]),
    .row_valid     (s_row_valid),
    .row_ready     (row_ready),
    .row_data      (s_row_data),
    .row_idx       (s_row_idx),
    .row_is_weight (s_row_is_weight),
    .preload_done  (s_preload_done),
    .busy          (s_busy)
`ifdef SA_LOADER_PARITY_EN
    ,
    .parity_in     (^data_in[1:0]),
    .parity_err    (s_parity_err)
`endif
  );

  logic         c_in_ready, c_row_valid, c_row_is_weight, c_preload_done, c_busy;
  logic [127:0] c_row_data;
  logic [3:0]   c_row_idx;
  assign c_in_ready      = sel ? s_in_ready      : b_in_ready;
  assign c_row_valid     = sel ? s_row_valid     : b_row_valid;
  assign c_row_is_weight = sel ? s_row_is_weight : b_row_is_weight;
  assign c_preload_done  = sel ? s_preload_done  : b_preload_done;
  assign c_busy          = sel ? s_busy          : b_busy;
  assign c_row_data      = sel ? {96'b0, s_row_data} : b_row_data;
  assign c_row_idx       = sel ? {2'b0, s_row_idx}   : b_row_idx;

  typedef struct {
    logic [127:0] data;
    int           idx;
    bit           w;
  } exp_t;
  exp_t         q[$];
  logic [127:0] seen [16];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Row contents by pattern: byte k of row r.
  function automatic logic [127:0] make_row(input int pat, input int r, input int size);
    logic [127:0] v;
    v = '0;
    for (int k = 0; k < size; k++) begin
      case (pat)
        0:       v[8*k +: 8] = 8'(16 * r + k + 1);
        1:       v[8*k +: 8] = 8'(r * 37 + k * 11 + 90);
        2:       v[8*k +: 8] = 8'(255 - r - 16 * k);
        default: v[8*k +: 8] = 8'((16 * r + k) ^ 8'hC3);
      endcase
    end
    return v;
  endfunction

  // Beat b of a row: lane j sends words j*wpl+wpl-1 down to j*wpl, each MSB first.
  function automatic logic [7:0] beat_bits(input logic [127:0] row, input int b,
                                           input int size, input int lanes);
    logic [7:0] v;
    int         wpl;
    int         w;
    v   = '0;
    wpl = size / lanes;
    for (int j = 0; j < lanes; j++) begin
      w    = j * wpl + (wpl - 1 - b / 8);
      v[j] = row[8 * w + 7 - b % 8];
    end
    return v;
  endfunction

  task automatic wait_ready();
    int guard;
    guard = 0;
    @(negedge clk);
    while (!c_in_ready && guard < 2000) begin
      guard++;
      @(negedge clk);
    end
    if (!c_in_ready) begin
      checks++;
      failures++;
      $display("FAIL in_ready_timeout: in_ready=0 required 1");
    end
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    @(negedge clk);
    while (c_busy && guard < 1000) begin
      guard++;
      @(negedge clk);
    end
    check("idle_reached", c_busy, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic m);
    start = 1'b1;
    mode  = m;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", c_busy, 1'b1);
  endtask

  task automatic send_row(input logic [127:0] row, input int idx, input bit w,
                          input int stop_beat, input int nbeats);
    int bpl;
    bpl = 8 * (cur_size / cur_lanes);
    if (nbeats >= bpl) q.push_back('{data: row, idx: idx, w: w});
    for (int b = 0; b < nbeats && b < bpl; b++) begin
      data_in  = beat_bits(row, b, cur_size, cur_lanes);
`ifdef SA_LOADER_PARITY_EN
      parity_in = (^data_in) ^ (b == flip_beat);
`endif
      in_valid = 1'b1;
      stop     = (b == stop_beat);
      wait_ready();
`ifdef SA_LOADER_PARITY_EN
      if (b == flip_beat) check("parity_err_before", b_parity_err, 1'b0);
`endif
      @(posedge clk);
      #1;
`ifdef SA_LOADER_PARITY_EN
      if (b == flip_beat) check("parity_err_set", b_parity_err, 1'b1);
`endif
      stop = 1'b0;
    end
    in_valid = 1'b0;
  endtask

  // Compare process: reset values, row scoreboard, hold stability, done timing.
  initial begin
    logic         prev_stall, hs, last, hs_d1, hs_d2, hs_d3;
    logic [127:0] prev_data;
    logic [3:0]   prev_idx;
    exp_t         e;
    prev_stall = 1'b0;
    hs_d1 = 1'b0;
    hs_d2 = 1'b0;
    hs_d3 = 1'b0;
    prev_data = '0;
    prev_idx = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_row_valid", c_row_valid, 1'b0);
        check("rst_row_data", c_row_data, 128'd0);
        check("rst_row_idx", c_row_idx, 4'd0);
        check("rst_row_is_weight", c_row_is_weight, 1'b0);
        check("rst_preload_done", c_preload_done, 1'b0);
        check("rst_in_ready", c_in_ready, 1'b0);
        check("rst_busy", c_busy, 1'b0);
        prev_stall = 1'b0;
        hs_d1 = 1'b0;
        hs_d2 = 1'b0;
        hs_d3 = 1'b0;
      end else begin
        hs = c_row_valid && row_ready;
        if (prev_stall) begin
          check("stall_row_valid", c_row_valid, 1'b1);
          check("stall_row_data", c_row_data, prev_data);
          check("stall_row_idx", c_row_idx, prev_idx);
        end
        check("preload_done_timing", c_preload_done, hs_d2);
        if (hs_d3) check("busy_after_done", c_busy, 1'b0);
        if (c_preload_done) done_cnt++;
        if (hs) begin
          if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL extra_row: got row idx %0d required no row", c_row_idx);
          end else begin
            e = q.pop_front();
            check("row_data", c_row_data, e.data);
            check("row_idx", c_row_idx, 128'(e.idx));
            check("row_is_weight", c_row_is_weight, e.w);
          end
          seen[c_row_idx] = c_row_data;
        end
        last  = hs && c_row_is_weight && (int'(c_row_idx) == cur_size - 1);
        hs_d3 = hs_d2;
        hs_d2 = hs_d1;
        hs_d1 = last;
        prev_stall = c_row_valid && !row_ready;
        prev_data  = c_row_data;
        prev_idx   = c_row_idx;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int stall_guard;
    // Pin the lane-mapping model with hand-derived beats.
    check("model_beat_16x8", beat_bits(make_row(0, 0, 16), 6, 16, 8), 8'h55);
    check("model_beat_4x2", beat_bits(make_row(2, 9, 4), 2, 4, 2), 8'h01);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Preload with row_ready held high; also pin the first-row latency.
    start_load(1'b1);
    for (int r = 0; r < 16; r++) begin
      send_row(make_row(0, r, 16), r, 1'b1, -1, 16);
      if (r == 0) begin
        @(negedge clk);
        check("latency_edge_n", c_row_valid, 1'b0);
        @(negedge clk);
        check("latency_edge_n1", c_row_valid, 1'b1);
        check("latency_idx", c_row_idx, 4'd0);
        @(posedge clk);
        #1;
      end
    end
    wait_idle();
    check("preload_a_done_count", 128'(done_cnt), 128'd1);
    check("preload_a_queue_empty", 128'(q.size()), 128'd0);
    check("row0_byte0", seen[0][7:0], 8'h01);
    check("row15_byte15", seen[15][127:120], 8'h00);
    check("row15_byte0", seen[15][7:0], 8'hF1);

    // Preload under back-pressure: row_ready low for 40 cycles after row 0.
    row_ready = 1'b0;
    start_load(1'b1);
    fork
      begin
        for (int r = 0; r < 16; r++) send_row(make_row(1, r, 16), r, 1'b1, -1, 16);
      end
      begin
        stall_guard = 0;
        while (!c_row_valid && stall_guard < 500) begin
          stall_guard++;
          @(negedge clk);
        end
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("bp_in_ready_low", c_in_ready, 1'b0);
        check("bp_row_valid", c_row_valid, 1'b1);
        check("bp_row_idx", c_row_idx, 4'd0);
        @(posedge clk);
        #1 row_ready = 1'b1;
      end
    join
    wait_idle();
    check("preload_b_done_count", 128'(done_cnt), 128'd2);
    check("preload_b_queue_empty", 128'(q.size()), 128'd0);

    // Stream on the 4x2 instance: 10 rows, stop mid-row 9.
    sel       = 1'b1;
    cur_size  = 4;
    cur_lanes = 2;
    start_load(1'b0);
    for (int n = 0; n < 10; n++) begin
      send_row(make_row(2, n, 4), n % 4, 1'b0, (n == 9) ? 8 : -1, 16);
    end
    wait_idle();
    check("stream_no_done", 128'(done_cnt), 128'd2);
    check("stream_queue_empty", 128'(q.size()), 128'd0);
    check("stream_row9_byte0", seen[1][7:0], 8'hF6);
    check("stream_row9_byte1", seen[1][15:8], 8'hE6);
    check("stream_in_ready_idle", c_in_ready, 1'b0);

    // Reset in the middle of a row on the 16x8 instance.
    sel       = 1'b0;
    cur_size  = 16;
    cur_lanes = 8;
    start_load(1'b1);
    send_row(make_row(3, 7, 16), 0, 1'b1, -1, 5);
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", c_busy, 1'b0);
    check("async_rst_is_weight", c_row_is_weight, 1'b0);
    check("async_rst_in_ready", c_in_ready, 1'b0);
    check("async_rst_row_valid", c_row_valid, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Preload with an ignored start while busy and an ignored stop.
    start_load(1'b1);
    for (int r = 0; r < 16; r++) begin
      if (r == 5) begin
        start = 1'b1;
        mode  = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
      end
      send_row(make_row(3, r, 16), r, 1'b1, (r == 2) ? 4 : -1, 16);
    end
    wait_idle();
    check("preload_d_done_count", 128'(done_cnt), 128'd3);
    check("preload_d_queue_empty", 128'(q.size()), 128'd0);
    check("preload_d_row0", seen[0], make_row(3, 0, 16));

`ifdef SA_LOADER_PARITY_EN
    // Bad parity on beat 7 of row 0: sticky until the next start.
    start_load(1'b1);
    for (int r = 0; r < 16; r++) begin
      flip_beat = (r == 0) ? 7 : -1;
      send_row(make_row(0, r, 16), r, 1'b1, -1, 16);
    end
    wait_idle();
    check("parity_err_sticky", b_parity_err, 1'b1);
    start_load(1'b1);
    check("parity_err_cleared", b_parity_err, 1'b0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sa_serial_loader.md
Name: sa_serial_loader

Overview:
Bit-serial front-end loader for the systolic array. It takes IN_LANES serial lanes, MSB-first, and assembles complete SIZE-byte rows. Each row is handed to the array over a valid/ready row interface.
- Weight-preload mode: counts exactly SIZE rows, then signals completion.
- Stream mode: delivers activation rows continuously until stopped.
- Replaces the hard-wired two-words-per-lane preload sequencing with a parametrised, back-pressured FSM.

Parameters:
SIZE, 16, array dimension; bytes per row; must be a multiple of IN_LANES
IN_LANES, 8, number of serial input lanes
WPL, SIZE/IN_LANES, derived (localparam); 8-bit words carried per lane per row
BPL, 8*WPL, derived (localparam); bits per lane per row

Ports:
clk  input  1  single system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  pulse in IDLE; begins a load
mode  input  1  sampled with start; 0 = stream activations, 1 = weight preload
stop  input  1  stream mode only; end at next row boundary
in_valid  input  1  data_in beat valid
in_ready  output  1  loader accepts a beat this cycle
data_in  input  IN_LANES  one bit per lane per beat
row_valid  output  1  row_data holds a complete row
row_ready  input  1  array consumes the row
row_data  output  8*SIZE  byte k at [8k+:8]
row_idx  output  $clog2(SIZE)  index of the presented row
row_is_weight  output  1  presented row belongs to a preload
preload_done  output  1  one-cycle pulse after the last weight row is consumed
busy  output  1  FSM not in IDLE

Behaviour:
- Reset (asynchronous, rst_n low): FSM=IDLE; bit counter and row counter = 0; holding register empty.
- Reset outputs: row_valid=0, row_data=0, row_idx=0, row_is_weight=0, preload_done=0, in_ready=0, busy=0.
- Reset mid-load discards all partial data; no row is emitted.
- Lane mapping: lane j carries words j*WPL+WPL-1 down to j*WPL, highest index first, each word MSB-first.
  - Example, SIZE=16, IN_LANES=8: lane 0 sends byte1[7..0], then byte0[7..0].
- A beat transfers when in_valid && in_ready. Each lane shifts its bit into its own BPL-bit shift register; the bit counter increments.
- On the beat that makes the bit count reach BPL:
  - the assembled row moves to the holding register next cycle;
  - row_valid=1, row_idx=row counter, row counter increments;
  - bit counter returns to 0.
  - Latency: last bit accepted at edge N, row_valid high after edge N+1.
- Back-pressure: a row leaves the holding register on row_valid && row_ready.
  - If the holding register is occupied and the shift registers hold a complete row, in_ready=0. No bit is ever lost.
  - Simultaneous hand-off and refill in the same cycle is allowed, giving full throughput.
- in_ready is 1 only in LOAD, subject to the back-pressure rule above.
- FSM states and transitions:
  - IDLE: start → LOAD; clears counters; latches mode into row_is_weight.
  - LOAD, preload: after row SIZE-1 is assembled → DRAIN.
  - LOAD, stream: the row counter wraps modulo SIZE. stop is latched (sticky) and acted on when the bit count is 0 → DRAIN. A partial row is always completed before stopping.
  - DRAIN: waits until the holding register is empty.
    - Preload: → DONE.
    - Stream: → IDLE.
  - DONE: preload_done=1 for exactly one cycle → IDLE.
- start outside IDLE is ignored. stop in preload mode is ignored.
- row_data holds its value while row_valid && !row_ready.

Optional Feature:
Macro SA_LOADER_PARITY_EN.
- Defined:
  - Adds input parity_in (1 bit; even parity over data_in, checked per accepted beat).
  - Adds output parity_err (sticky). It sets on a mismatching accepted beat, clears on start or reset, and is visible the cycle after the bad beat.
- Undefined: neither port exists and no parity logic is present.

Decomposition:
- Shared package sa_pkg holds:
  - mode encodings MODE_STREAM=1'b0 and MODE_PRELOAD=1'b1;
  - FSM state typedef (IDLE, LOAD, DRAIN, DONE);
  - width helper BYTE_W=8.
- One natural sub-module, sa_lane_shifter: a per-lane BPL-bit MSB-first shift register with word unpacking, instantiated IN_LANES times.

Test Plan:
- Preload, SIZE=16, IN_LANES=8, row_ready=1. Drive byte k of row r = 16r+k+1.
  → 16 rows, row_idx 0..15, row_is_weight=1, row 0 byte 0 = 0x01, row 15 byte 15 = 0x00 (256 truncated to 8 bits).
  → preload_done pulses once, 1 cycle after row 15 handshake; busy falls next cycle.
- Back-pressure: row_ready=0 for 40 cycles after row 0.
  → in_ready drops after row 1 completes; row_data stable; no corruption.
  → After release, rows 0 and 1 appear in order and the second load continues.
- Stream mode, SIZE=4, IN_LANES=2, 10 rows with values 0xFF-n; stop asserted mid-row 9.
  → row_idx sequence 0,1,2,3,0,1,...,1.
  → Row 9 is completed, FSM returns to IDLE, preload_done never pulses.
- Reset mid-row (rst_n low 3 cycles after 5 beats).
  → All outputs at reset values immediately.
  → The next preload produces correct row 0 with no leftover bits.
- start while busy, and stop during preload: both ignored; exactly SIZE rows are produced.
- With SA_LOADER_PARITY_EN: flip parity_in on beat 7.
  → parity_err=1 from the next cycle and stays high until the next start.
